// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch unit, the control FSM, the instruction memory port and the IR.
// The master modport is the fetch unit itself. The slave modport is its environment.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              fetch_req;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic [31:0]       instruction;
  logic              write_ir;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fetch_err;

  modport master (
    input  fetch_req, pc_load, pc_target, mem_rdata, mem_ready,
    output mem_addr, mem_rd, instruction, write_ir, pc, busy, fetch_err
  );

  modport slave (
    output fetch_req, pc_load, pc_target, mem_rdata, mem_ready,
    input  mem_addr, mem_rd, instruction, write_ir, pc, busy, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Owns the program counter and fetches one instruction word per request.
// Each word is handed to the instruction register with a one-cycle write_ir strobe.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  instr_fetch_unit_if.master         bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_next_pc;
  logic              r_pend_valid, w_next_pend_valid;
  logic [ADDR_W-1:0] r_pend_target, w_next_pend_target;
  logic [CNT_W-1:0]  r_count, w_next_count;
  logic [31:0]       r_instruction, w_next_instruction;
  logic              r_write_ir, w_next_write_ir;
  logic              r_fetch_err, w_next_fetch_err;

  logic              w_aligned;
  logic              w_good_load;
  logic              w_eff_pend_valid;
  logic [ADDR_W-1:0] w_eff_pend_target;

  assign w_aligned   = (bus.pc_target[1:0] == 2'b00);
  assign w_good_load = bus.pc_load && w_aligned;

  // A redirect that arrives in the same cycle as the fetch resolves still counts as pending.
  assign w_eff_pend_valid  = r_pend_valid || w_good_load;
  assign w_eff_pend_target = w_good_load ? bus.pc_target : r_pend_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_count       <= '0;
      r_instruction <= '0;
      r_write_ir    <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_pend_valid  <= w_next_pend_valid;
      r_pend_target <= w_next_pend_target;
      r_count       <= w_next_count;
      r_instruction <= w_next_instruction;
      r_write_ir    <= w_next_write_ir;
      r_fetch_err   <= w_next_fetch_err;
    end
  end

  always_comb begin
    w_next_state       = r_state;
    w_next_pc          = r_pc;
    w_next_pend_valid  = r_pend_valid;
    w_next_pend_target = r_pend_target;
    w_next_count       = r_count;
    w_next_instruction = r_instruction;
    w_next_write_ir    = 1'b0;
    w_next_fetch_err   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_next_pend_valid = 1'b0;
        if (bus.pc_load) begin
          if (w_aligned) w_next_pc = bus.pc_target;
          else           w_next_fetch_err = 1'b1;
        end
        if (bus.fetch_req) begin
          w_next_state = WAIT;
          w_next_count = '0;
        end
      end
      WAIT: begin
        if (bus.mem_ready) begin
          // write_ir wins over a misaligned redirect error so the two strobes stay exclusive.
          w_next_instruction = bus.mem_rdata;
          w_next_write_ir    = 1'b1;
          w_next_pc          = w_eff_pend_valid ? w_eff_pend_target : r_pc + ADDR_W'(4);
          w_next_pend_valid  = 1'b0;
          w_next_state       = IDLE;
        end else if (r_count == CNT_W'(TIMEOUT - 1)) begin
          w_next_fetch_err  = 1'b1;
          w_next_pc         = w_eff_pend_valid ? w_eff_pend_target : r_pc;
          w_next_pend_valid = 1'b0;
          w_next_state      = IDLE;
        end else begin
          w_next_count       = r_count + CNT_W'(1);
          w_next_pend_valid  = w_eff_pend_valid;
          w_next_pend_target = w_eff_pend_target;
          w_next_fetch_err   = bus.pc_load && !w_aligned;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.mem_addr    = r_pc;
  assign bus.pc          = r_pc;
  assign bus.mem_rd      = (r_state == WAIT);
  assign bus.busy        = (r_state == WAIT);
  assign bus.instruction = r_instruction;
  assign bus.write_ir    = r_write_ir;
  assign bus.fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Expected fetched words and next-PC values are queued when memory responds and are checked when write_ir fires.
module tb_instr_fetch_unit;
  localparam int ADDR_W  = 64;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    int                cycle;
  } expect_t;

  logic clk;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  int   cycleCount  = 0;
  logic [ADDR_W-1:0] modelPc;
  logic [31:0]       lastInstr;
  expect_t           sbQueue[$];

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC('0), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fr, input logic pl, input logic [ADDR_W-1:0] tgt,
                               input logic rdy, input logic [31:0] rdata);
    bus.fetch_req = fr;
    bus.pc_load   = pl;
    bus.pc_target = tgt;
    bus.mem_ready = rdy;
    bus.mem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  // loadMode: 0 no redirect, 1 aligned redirect in the first WAIT cycle, 2 redirect alongside mem_ready
  task automatic fetchWord(input logic [31:0] data, input int waits, input int loadMode,
                           input logic [ADDR_W-1:0] tgt);
    logic              pend;
    logic [ADDR_W-1:0] nextPc;
    pend = 1'b0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    checkOutput("busy_wait", 64'(bus.busy), 64'd1);
    checkOutput("mem_rd_wait", 64'(bus.mem_rd), 64'd1);
    checkOutput("mem_addr_wait", bus.mem_addr, modelPc);
    for (int i = 0; i < waits; i++) begin
      applyStimulus(1'b0, (loadMode == 1) && (i == 0), tgt, 1'b0, '0);
      if ((loadMode == 1) && (i == 0)) pend = 1'b1;
      checkOutput("mem_addr_hold", bus.mem_addr, modelPc);
      checkOutput("busy_hold", 64'(bus.busy), 64'd1);
    end
    if (loadMode == 2) pend = 1'b1;
    nextPc = pend ? tgt : modelPc + 64'd4;
    sbQueue.push_back('{data, nextPc, cycleCount + 1});
    applyStimulus(1'b0, loadMode == 2, tgt, 1'b1, data);
    modelPc   = nextPc;
    lastInstr = data;
    checkOutput("busy_done", 64'(bus.busy), 64'd0);
    checkOutput("pc_done", bus.pc, modelPc);
  endtask

  // The scoreboard side: write_ir must fire exactly on the cycle a queued word is due.
  always @(negedge clk) begin
    logic expWir;
    expWir = (sbQueue.size() > 0) && (sbQueue[0].cycle == cycleCount);
    checkOutput("write_ir", 64'(bus.write_ir), 64'(expWir));
    if (bus.write_ir && bus.fetch_err) checkOutput("ir_err_exclusive", 64'(bus.fetch_err), 64'd0);
    if (expWir) begin
      checkOutput("instruction", 64'(bus.instruction), 64'(sbQueue[0].instr));
      checkOutput("pc_after_fetch", bus.pc, sbQueue[0].pc);
      void'(sbQueue.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset         = 1'b1;
    bus.fetch_req = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_target = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    modelPc       = '0;
    lastInstr     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pc", bus.pc, 64'd0);
    checkOutput("rst_instruction", 64'(bus.instruction), 64'd0);
    checkOutput("rst_fetch_err", 64'(bus.fetch_err), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic fetch with three wait states, then back-to-back zero-wait fetches
    fetchWord(32'h00A28020, 3, 0, '0);
    fetchWord(32'h11111111, 0, 0, '0);
    fetchWord(32'h22222222, 0, 0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("write_ir_one_cycle", 64'(bus.write_ir), 64'd0);

    // Redirect during WAIT takes effect after the current fetch
    fetchWord(32'h33333333, 2, 1, 64'h1000);
    fetchWord(32'h44444444, 0, 0, '0);
    fetchWord(32'h55555555, 1, 2, 64'h3000);

    // Misaligned redirect in IDLE, then aligned redirect together with fetch_req
    applyStimulus(1'b0, 1'b1, 64'h2002, 1'b0, '0);
    checkOutput("misaligned_err", 64'(bus.fetch_err), 64'd1);
    checkOutput("misaligned_pc", bus.pc, modelPc);
    applyStimulus(1'b1, 1'b1, 64'h2000, 1'b0, '0);
    checkOutput("err_one_cycle", 64'(bus.fetch_err), 64'd0);
    checkOutput("load_fetch_addr", bus.mem_addr, 64'h2000);
    modelPc = 64'h2000;
    sbQueue.push_back('{32'h89ABCDEF, 64'h2004, cycleCount + 1});
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h89ABCDEF);
    modelPc   = 64'h2004;
    lastInstr = 32'h89ABCDEF;

    // Misaligned redirect with fetch_req: fetch proceeds at the old pc
    applyStimulus(1'b1, 1'b1, 64'h2006, 1'b0, '0);
    checkOutput("mis_fetch_err", 64'(bus.fetch_err), 64'd1);
    checkOutput("mis_fetch_addr", bus.mem_addr, modelPc);
    sbQueue.push_back('{32'h0BADF00D, modelPc + 64'd4, cycleCount + 1});
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h0BADF00D);
    modelPc   = modelPc + 64'd4;
    lastInstr = 32'h0BADF00D;

    // Timeout: mem_ready never arrives
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      n++;
      if (bus.fetch_err) break;
    end
    checkOutput("timeout_err", 64'(bus.fetch_err), 64'd1);
    checkOutput("timeout_cycles", 64'(n), 64'(TIMEOUT));
    checkOutput("timeout_busy", 64'(bus.busy), 64'd0);
    checkOutput("timeout_pc", bus.pc, modelPc);
    checkOutput("timeout_instr", 64'(bus.instruction), 64'(lastInstr));
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("timeout_err_pulse", 64'(bus.fetch_err), 64'd0);

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, '0);
    modelPc = 64'hFFFF_FFFF_FFFF_FFFC;
    checkOutput("wrap_load_pc", bus.pc, modelPc);
    fetchWord(32'h66666666, 0, 0, '0);
    checkOutput("wrap_pc_zero", bus.pc, 64'd0);

    // Reset in the middle of a fetch
    fetchWord(32'h77777777, 0, 0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_mem_rd", 64'(bus.mem_rd), 64'd0);
    checkOutput("rst_mid_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_mid_pc", bus.pc, 64'd0);
    checkOutput("rst_mid_instr", 64'(bus.instruction), 64'd0);
    @(negedge clk);
    reset   = 1'b0;
    modelPc = '0;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("late_ready_instr", 64'(bus.instruction), 64'd0);
    checkOutput("late_ready_busy", 64'(bus.busy), 64'd0);
    checkOutput("late_ready_pc", bus.pc, modelPc);

    @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sbQueue.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
